// File: rtl/clock_pkg.sv
// Shared BCD constants and an elaboration-time decimal-to-BCD helper
// used to turn decimal range parameters into packed BCD words.
package clock_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 4;

    function automatic logic [BCD_W*MAX_DIGITS-1:0] dec_to_bcd(input int unsigned value);
        logic [BCD_W*MAX_DIGITS-1:0] bcd;
        int unsigned                 rem;
        bcd = '0;
        rem = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            bcd[i*BCD_W +: BCD_W] = BCD_W'(rem % 10);
            rem = rem / 10;
        end
        return bcd;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: steps up or down when cin is set, raising cout on the
// 9->0 carry (up) or the 0->9 borrow (down) so decades can be chained.
module bcd_digit
    import clock_pkg::*;
(
    input  logic [BCD_W-1:0] d,
    input  logic             up,
    input  logic             cin,
    output logic [BCD_W-1:0] q,
    output logic             cout
);

    always_comb begin
        q    = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (d >= 4'd9) begin
                    q    = 4'd0;
                    cout = 1'b1;
                end else begin
                    q = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    q    = 4'd9;
                    cout = 1'b1;
                end else begin
                    q = d - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_range_counter.sv
// Up/down BCD counter confined to one of two decimal ranges, with validated
// synchronous load and a combinational terminal-count output for cascading.
module bcd_range_counter
    import clock_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int LO_A   = 0,
    parameter int HI_A   = 59,
    parameter int LO_B   = 1,
    parameter int HI_B   = 12
) (
    input  logic                    CP,
    input  logic                    nCR,
    input  logic                    EN,
    input  logic                    UP,
    input  logic                    MODE,
    input  logic                    LD,
    input  logic [BCD_W*DIGITS-1:0] D,
    output logic [BCD_W*DIGITS-1:0] Q,
    output logic                    sCo,
    output logic                    ld_err
);

    localparam int W = BCD_W * DIGITS;

    generate
        if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
            $error("bcd_range_counter: DIGITS must be 1..%0d", MAX_DIGITS);
        end
        if (LO_A < 0 || LO_A > HI_A || HI_A >= 10**DIGITS) begin : g_bad_range_a
            $error("bcd_range_counter: illegal range A %0d..%0d", LO_A, HI_A);
        end
        if (LO_B < 0 || LO_B > HI_B || HI_B >= 10**DIGITS) begin : g_bad_range_b
            $error("bcd_range_counter: illegal range B %0d..%0d", LO_B, HI_B);
        end
    endgenerate

    localparam logic [W-1:0] LO_A_BCD = W'(dec_to_bcd(LO_A));
    localparam logic [W-1:0] HI_A_BCD = W'(dec_to_bcd(HI_A));
    localparam logic [W-1:0] LO_B_BCD = W'(dec_to_bcd(LO_B));
    localparam logic [W-1:0] HI_B_BCD = W'(dec_to_bcd(HI_B));

    logic [W-1:0]        q_reg, q_next;
    logic                ld_err_reg, ld_err_next;
    logic [W-1:0]        lo_sel, hi_sel, step_q;
    logic [DIGITS:0]     carry;
    logic [DIGITS-1:0]   d_digit_ok;
    logic                in_range, d_valid, carry_unused;

    assign lo_sel = MODE ? LO_B_BCD : LO_A_BCD;
    assign hi_sel = MODE ? HI_B_BCD : HI_A_BCD;

    // Valid BCD words order the same way as their decimal values, so plain
    // unsigned compares serve as decimal range checks.
    assign in_range = (q_reg >= lo_sel) && (q_reg <= hi_sel);
    assign d_valid  = (&d_digit_ok) && (D >= lo_sel) && (D <= hi_sel);

    assign carry[0]     = 1'b1;
    assign carry_unused = carry[DIGITS];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign d_digit_ok[gi] = (D[gi*BCD_W +: BCD_W] <= 4'd9);

            bcd_digit u_digit (
                .d    (q_reg[gi*BCD_W +: BCD_W]),
                .up   (UP),
                .cin  (carry[gi]),
                .q    (step_q[gi*BCD_W +: BCD_W]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign sCo = EN & (UP ? (q_reg == hi_sel) : (q_reg == lo_sel));

    always_comb begin
        q_next      = q_reg;
        ld_err_next = 1'b0;
        if (LD) begin
            if (d_valid) begin
                q_next = D;
            end else begin
                ld_err_next = 1'b1;
            end
        end else if (EN) begin
            if (!in_range) begin
                q_next = UP ? lo_sel : hi_sel;
            end else if (UP && (q_reg == hi_sel)) begin
                q_next = lo_sel;
            end else if (!UP && (q_reg == lo_sel)) begin
                q_next = hi_sel;
            end else begin
                q_next = step_q;
            end
        end
    end

    always_ff @(posedge CP) begin
        if (!nCR) begin
            q_reg      <= MODE ? LO_B_BCD : LO_A_BCD;
            ld_err_reg <= 1'b0;
        end else begin
            q_reg      <= q_next;
            ld_err_reg <= ld_err_next;
        end
    end

    assign Q      = q_reg;
    assign ld_err = ld_err_reg;

endmodule
